// File: rtl/spike_packet_reader_if.sv
// FIFO read port and snapshot stream of the spike packet reader.
// master = reader side, slave = FIFO / decoder side.
interface spike_packet_reader_if;
    logic        fifo_rd;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic [63:0] snap_data;
    logic        snap_bank;
    logic [2:0]  snap_idx;
    logic        snap_valid;
    logic        snap_ready;
    logic        pkt_done;
    logic [10:0] pkt_spike_total;

    modport master (
        output fifo_rd, snap_data, snap_bank, snap_idx, snap_valid, pkt_done, pkt_spike_total,
        input  fifo_empty, fifo_dout, snap_ready
    );

    modport slave (
        input  fifo_rd, snap_data, snap_bank, snap_idx, snap_valid, pkt_done, pkt_spike_total,
        output fifo_empty, fifo_dout, snap_ready
    );
endinterface

// File: rtl/spike_packet_reader.sv
// Reads 64-word spike packets from the spike FIFO, rebuilds 64-bit channel snapshots
// and reports per-packet spike totals and the number of packets waiting.
module spike_packet_reader #(
    parameter int SNAPS_PER_BANK = 8,
    parameter int PKT_CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pkt_wr_done,
    output logic [PKT_CNT_W-1:0] pkt_pending,
    output logic                 pkt_ovf,
    spike_packet_reader_if.master bus
);
    localparam int SNAP_CNT_W = $clog2(2 * SNAPS_PER_BANK);
    localparam logic [SNAP_CNT_W-1:0] LAST_SNAP = SNAP_CNT_W'(2 * SNAPS_PER_BANK - 1);
    localparam logic [PKT_CNT_W-1:0]  PEND_MAX  = '1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, HOLD, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            rd_cnt_q, rd_cnt_d;
    logic [1:0]            slot_q, slot_d;
    logic                  rd_q, rd_d;
    logic [63:0]           data_q, data_d;
    logic [SNAP_CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic [10:0]           acc_q, acc_d;
    logic [10:0]           total_q, total_d;
    logic [PKT_CNT_W-1:0]  pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    logic                  start;

    function automatic logic [4:0] popcount16(input logic [15:0] w);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(w[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            slot_q     <= '0;
            rd_q       <= 1'b0;
            data_q     <= '0;
            snap_cnt_q <= '0;
            acc_q      <= '0;
            total_q    <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            slot_q     <= slot_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            snap_cnt_q <= snap_cnt_d;
            acc_q      <= acc_d;
            total_q    <= total_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
        end
    end

    // A start and a new packet in the same cycle cancel; a full counter drops the packet and flags it.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        start  = (state_q == IDLE) && (pend_q != '0);
        if (pkt_wr_done && !start) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (start && !pkt_wr_done) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        slot_d     = slot_q;
        data_d     = data_q;
        snap_cnt_d = snap_cnt_q;
        acc_d      = acc_q;
        total_d    = total_q;
        rd_d       = (state_q == READ) && (rd_cnt_q < 3'd4) && !bus.fifo_empty;

        // FIFO data lags the strobe by one cycle, so captures follow the delayed strobe.
        if (rd_q) begin
            case (slot_q)
                2'd0:    data_d[15:0]  = bus.fifo_dout;
                2'd1:    data_d[31:16] = bus.fifo_dout;
                2'd2:    data_d[47:32] = bus.fifo_dout;
                default: data_d[63:48] = bus.fifo_dout;
            endcase
            slot_d = slot_q + 2'd1;
            acc_d  = acc_q + 11'(popcount16(bus.fifo_dout));
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = READ;
                    rd_cnt_d   = '0;
                    slot_d     = '0;
                    snap_cnt_d = '0;
                    acc_d      = '0;
                end
            end
            READ: begin
                if (rd_d) begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                    if (rd_cnt_q == 3'd3) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.snap_ready) begin
                    snap_cnt_d = snap_cnt_q + 1'b1;
                    rd_cnt_d   = '0;
                    if (snap_cnt_q == LAST_SNAP) begin
                        state_d = DONE;
                        total_d = acc_q;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.fifo_rd         = rd_d;
    assign bus.snap_data       = data_q;
    assign bus.snap_bank       = snap_cnt_q[SNAP_CNT_W-1];
    assign bus.snap_idx        = 3'(snap_cnt_q[SNAP_CNT_W-2:0]);
    assign bus.snap_valid      = (state_q == HOLD);
    assign bus.pkt_done        = (state_q == DONE);
    assign bus.pkt_spike_total = total_q;
    assign pkt_pending         = pend_q;
    assign pkt_ovf             = ovf_q;
endmodule

// File: tb/tb_spike_packet_reader.sv
// Bench for spike_packet_reader: a queue-based FIFO, a per-packet snapshot/total
// scoreboard built from the packet layout, directed corner cases and random traffic.
module tb_spike_packet_reader;
    localparam int SNAPS_PER_BANK = 8;
    localparam int PKT_CNT_W      = 3;
    localparam int PKT_WORDS      = 8 * SNAPS_PER_BANK;
    localparam int SNAPS          = 2 * SNAPS_PER_BANK;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 pkt_wr_done = 1'b0;
    logic [PKT_CNT_W-1:0] pkt_pending;
    logic                 pkt_ovf;

    spike_packet_reader_if bus ();

    spike_packet_reader #(
        .SNAPS_PER_BANK(SNAPS_PER_BANK),
        .PKT_CNT_W     (PKT_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_wr_done(pkt_wr_done),
        .pkt_pending(pkt_pending),
        .pkt_ovf    (pkt_ovf),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] fifo_q[$];
    int          fifo_cnt = 0;
    logic        force_empty = 1'b0;
    assign bus.fifo_empty = force_empty || (fifo_cnt == 0);

    logic [63:0] exp_snap[$];
    logic [3:0]  exp_tag[$];
    logic [10:0] exp_total[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cycle = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int first_rd_cycle = -1;
    int last_done_cycle = -1;
    int wr_cycle = 0;
    bit rand_ready = 1'b0;
    bit rand_empty = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock: monitor outputs at the falling edge, then serve the FIFO and drive inputs after the rising edge.
    task automatic tick();
        logic rd_now;
        @(negedge clk);
        cycle++;
        rd_now = bus.fifo_rd;
        if (bus.fifo_empty) checkOutput("rd_while_empty", 64'(bus.fifo_rd), 64'd0);
        if (bus.snap_valid) begin
            checkOutput("rd_during_hold", 64'(bus.fifo_rd), 64'd0);
            if (exp_snap.size() == 0) begin
                checkOutput("spurious_snap_valid", 64'(bus.snap_valid), 64'd0);
            end else begin
                checkOutput("snap_data", bus.snap_data, exp_snap[0]);
                checkOutput("snap_bank_idx", 64'({bus.snap_bank, bus.snap_idx}), 64'(exp_tag[0]));
                if (bus.snap_ready) begin
                    void'(exp_snap.pop_front());
                    void'(exp_tag.pop_front());
                    hs_cnt++;
                end
            end
        end
        if (bus.pkt_done) begin
            done_cnt++;
            last_done_cycle = cycle;
            if (exp_total.size() == 0) checkOutput("spurious_pkt_done", 64'(bus.pkt_done), 64'd0);
            else checkOutput("pkt_spike_total", 64'(bus.pkt_spike_total), 64'(exp_total.pop_front()));
        end
        if (rd_now && first_rd_cycle < 0) first_rd_cycle = cycle;
        @(posedge clk);
        #1;
        if (rd_now && fifo_cnt > 0) begin
            bus.fifo_dout = fifo_q.pop_front();
            fifo_cnt--;
        end
        if (rand_ready) bus.snap_ready = ($urandom_range(0, 3) != 0);
        if (rand_empty) force_empty = ($urandom_range(0, 4) == 0);
    endtask

    // Writes one packet into the FIFO, records its expected snapshots and total, then pulses pkt_wr_done.
    task automatic applyStimulus(input int mode);
        logic [15:0] w [PKT_WORDS];
        int total;
        total = 0;
        for (int i = 0; i < PKT_WORDS; i++) begin
            case (mode)
                0:       w[i] = 16'(i);
                1:       w[i] = 16'hFFFF;
                2:       w[i] = 16'h0000;
                3:       w[i] = 16'($urandom);
                default: w[i] = 16'($urandom) & 16'($urandom) & 16'($urandom);
            endcase
            total += $countones(w[i]);
            fifo_q.push_back(w[i]);
            fifo_cnt++;
        end
        for (int k = 0; k < SNAPS; k++) begin
            exp_snap.push_back({w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]});
            exp_tag.push_back(4'(k));
        end
        exp_total.push_back(11'(total));
        pkt_wr_done = 1'b1;
        tick();
        wr_cycle = cycle;
        pkt_wr_done = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) checkOutput("pkt_done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_fifo_rd"}, 64'(bus.fifo_rd), 64'd0);
        checkOutput({tag, "_snap_data"}, bus.snap_data, 64'd0);
        checkOutput({tag, "_bank_idx"}, 64'({bus.snap_bank, bus.snap_idx}), 64'd0);
        checkOutput({tag, "_snap_valid"}, 64'(bus.snap_valid), 64'd0);
        checkOutput({tag, "_pkt_done"}, 64'(bus.pkt_done), 64'd0);
        checkOutput({tag, "_total"}, 64'(bus.pkt_spike_total), 64'd0);
        checkOutput({tag, "_pending"}, 64'(pkt_pending), 64'd0);
        checkOutput({tag, "_ovf"}, 64'(pkt_ovf), 64'd0);
    endtask

    task automatic clearAll();
        fifo_q.delete();
        fifo_cnt = 0;
        exp_snap.delete();
        exp_tag.delete();
        exp_total.delete();
        force_empty = 1'b0;
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        tick();
        clearAll();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int hs_base;
        bus.snap_ready = 1'b1;
        bus.fifo_dout  = 16'h0000;
        repeat (2) tick();
        checkResetState("por");
        rst_n = 1'b1;
        tick();

        $display("[TB] single ramp packet");
        first_rd_cycle = -1;
        applyStimulus(0);
        waitDone(done_cnt + 1, 300);
        checkOutput("first_read_latency", 64'(first_rd_cycle - wr_cycle), 64'd2);
        checkOutput("pkt_done_latency", 64'(last_done_cycle - first_rd_cycle), 64'd96);
        checkOutput("ramp_total", 64'(bus.pkt_spike_total), 64'd192);
        checkOutput("pkt_done_width", 64'(bus.pkt_done), 64'd0);
        checkOutput("pending_after_ramp", 64'(pkt_pending), 64'd0);

        $display("[TB] backpressure and empty stalls");
        hs_base = hs_cnt;
        applyStimulus(3);
        n = 0;
        while (hs_cnt < hs_base + 3 && n < 200) begin tick(); n++; end
        bus.snap_ready = 1'b0;
        n = 0;
        while (!bus.snap_valid && n < 50) begin tick(); n++; end
        checkOutput("stall_snap_idx", 64'(bus.snap_idx), 64'd3);
        repeat (10) tick();
        bus.snap_ready = 1'b1;
        n = 0;
        while (hs_cnt < hs_base + 5 && n < 200) begin tick(); n++; end
        force_empty = 1'b1;
        repeat (5) tick();
        force_empty = 1'b0;
        waitDone(done_cnt + 1, 400);

        $display("[TB] asynchronous reset mid-packet");
        applyStimulus(3);
        n = 0;
        while (!bus.fifo_rd && n < 20) begin tick(); n++; end
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 checkResetState("async");
        clearAll();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("idle_after_reset_valid", 64'(bus.snap_valid), 64'd0);
        checkOutput("idle_after_reset_rd", 64'(bus.fifo_rd), 64'd0);
        checkOutput("idle_after_reset_pending", 64'(pkt_pending), 64'd0);

        $display("[TB] pending counter saturation");
        applyStimulus(0);
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            pkt_wr_done = 1'b1;
            tick();
            pkt_wr_done = 1'b0;
            checkOutput("pending_sat", 64'(pkt_pending), (i < 7) ? 64'(i + 1) : 64'd7);
            checkOutput("ovf_flag", 64'(pkt_ovf), (i == 7) ? 64'd1 : 64'd0);
            tick();
        end
        waitDone(done_cnt + 1, 300);
        tick();
        checkOutput("pending_after_start", 64'(pkt_pending), 64'd6);
        checkOutput("ovf_sticky", 64'(pkt_ovf), 64'd1);
        resetPulse();
        checkOutput("ovf_cleared", 64'(pkt_ovf), 64'd0);

        $display("[TB] coincident write and start");
        pkt_wr_done = 1'b1;
        tick();
        checkOutput("pending_one", 64'(pkt_pending), 64'd1);
        tick();
        pkt_wr_done = 1'b0;
        checkOutput("pending_coincident", 64'(pkt_pending), 64'd1);
        resetPulse();

        $display("[TB] all-ones then all-zeros packets");
        applyStimulus(1);
        tick();
        applyStimulus(2);
        waitDone(done_cnt + 1, 400);
        checkOutput("ones_total", 64'(bus.pkt_spike_total), 64'd1024);
        waitDone(done_cnt + 1, 400);
        checkOutput("zeros_total", 64'(bus.pkt_spike_total), 64'd0);

        $display("[TB] random traffic");
        rand_ready = 1'b1;
        rand_empty = 1'b1;
        for (int p = 0; p < 3; p++) begin
            applyStimulus(3);
            applyStimulus(4);
            waitDone(done_cnt + 2, 1500);
        end
        rand_ready = 1'b0;
        rand_empty = 1'b0;
        bus.snap_ready = 1'b1;
        force_empty = 1'b0;
        repeat (5) tick();
        checkOutput("snapshots_drained", 64'(exp_snap.size()), 64'd0);
        checkOutput("totals_drained", 64'(exp_total.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
